// File: rtl/dcache.sv
// Direct-mapped, write-back / write-allocate data cache with 16-byte lines.
// A miss on a dirty victim writes that line back before the new line is filled.
module dcache #(
  parameter int IDX_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_rd,
  input  logic         cpu_wr,
  input  logic         cpu_byte,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         dhit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRBACK, FILL} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         wsel;
  logic               req, hit;
  logic               fill_en, store_en;

  assign idx  = cpu_addr[IDX_W+3:4];
  assign tag  = cpu_addr[31:IDX_W+4];
  assign wsel = cpu_addr[3:2];
  assign req  = cpu_rd | cpu_wr;
  assign hit  = (state_q == IDLE) & req & valid_q[idx] & (tag_q[idx] == tag);

  assign cpu_rdata = data_q[idx][{wsel, 5'b00000} +: 32];

  // Miss index/tag are latched so the transaction finishes even if the core drops its request.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    dhit       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_en    = 1'b0;
    store_en   = 1'b0;
    case (state_q)
      IDLE: begin
        dhit = ~req | hit;
        if (hit && cpu_wr) begin
          store_en     = 1'b1;
          dirty_d[idx] = 1'b1;
        end else if (req && !hit) begin
          miss_idx_d = idx;
          miss_tag_d = tag;
          state_d    = (valid_q[idx] && dirty_q[idx]) ? WRBACK : FILL;
        end
      end
      WRBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[miss_idx_q], miss_idx_q, 4'b0000};
        mem_wdata = data_q[miss_idx_q];
        if (mem_ready) state_d = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, miss_idx_q, 4'b0000};
        if (mem_ready) begin
          fill_en             = 1'b1;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    miss_idx_q <= miss_idx_d;
    miss_tag_q <= miss_tag_d;
    if (fill_en) begin
      data_q[miss_idx_q] <= mem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (store_en) begin
      if (cpu_byte) data_q[idx][{cpu_addr[3:0], 3'b000} +: 8] <= cpu_wdata[7:0];
      else          data_q[idx][{wsel, 5'b00000} +: 32]      <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Randomized scoreboard bench for dcache: an architectural memory model predicts
// load data and the write-back/fill traffic; a monitor compares as the DUT presents it.
module tb_dcache;
  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_rd, cpu_wr, cpu_byte;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         dhit, mem_req, mem_we, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache #(.IDX_W(2)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byte(cpu_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dhit(dhit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct { bit we; logic [31:0] addr; logic [127:0] data; } mtx_t;
  mtx_t         exp_mem[$];
  logic [31:0]  exp_rd[$];
  int           checks = 0, errors = 0;
  logic [127:0] bmem [64];
  logic [127:0] amem [64];
  int           cline [4];
  bit           cval [4], cdirty [4];
  int           lat_fixed = -1;
  bit           hold_ready = 0;
  int           resp_cycles = 0;
  logic [31:0]  last_rd;
  int           last_stall;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: four line slots keyed by line number, plus the architectural memory image.
  task automatic model_access(input logic [31:0] a, input bit wr, input bit byt,
                              input logic [31:0] wd, input bit live, output bit miss);
    int line, idx;
    mtx_t t;
    line = int'(a[9:4]);
    idx  = line % 4;
    miss = !(cval[idx] && cline[idx] == line);
    if (miss) begin
      if (cval[idx] && cdirty[idx]) begin
        t.we = 1'b1; t.addr = 32'(cline[idx] * 16); t.data = amem[cline[idx]];
        exp_mem.push_back(t);
      end
      t.we = 1'b0; t.addr = 32'(line * 16); t.data = '0;
      exp_mem.push_back(t);
      cval[idx] = 1; cline[idx] = line; cdirty[idx] = 0;
    end
    if (live) begin
      if (wr) begin
        if (byt) amem[line][int'(a[3:0]) * 8 +: 8] = wd[7:0];
        else     amem[line][int'(a[3:2]) * 32 +: 32] = wd;
        cdirty[idx] = 1;
      end else begin
        exp_rd.push_back(amem[line][int'(a[3:2]) * 32 +: 32]);
      end
    end
  endtask

  task automatic access(input logic [31:0] a, input bit wr, input bit rd, input bit byt,
                        input logic [31:0] wd);
    bit miss, done;
    int stall;
    model_access(a, wr, byt, wd, 1'b1, miss);
    resp_cycles = 0;
    cpu_addr = a; cpu_wr = wr; cpu_rd = rd; cpu_byte = byt; cpu_wdata = wd;
    done = 0; stall = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (dhit) begin done = 1; last_rd = cpu_rdata; end
      else stall++;
    end
    last_stall = stall;
    chk("access_done", 128'(done), 128'(1));
    chk("stall_cycles", 128'(stall), 128'(miss ? 1 + resp_cycles : 0));
    @(posedge clk); #1;
    cpu_rd = 0; cpu_wr = 0;
  endtask

  task automatic do_reset();
    reset = 1; cpu_rd = 0; cpu_wr = 0;
    exp_mem.delete(); exp_rd.delete();
    for (int i = 0; i < 4; i++) begin cval[i] = 0; cdirty[i] = 0; cline[i] = 0; end
    for (int i = 0; i < 64; i++) amem[i] = bmem[i];
    repeat (2) @(posedge clk);
    #2 reset = 0;
    @(posedge clk); #1;
  endtask

  // Memory responder: latency counted in cycles of mem_req before the mem_ready cycle.
  initial begin : responder
    int cnt, d;
    bit active;
    active = 0; cnt = 0; d = 0;
    mem_ready = 0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        active = 0; mem_ready = 0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1; cnt = 0;
          d = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 5));
        end
        if (!hold_ready && cnt == d) begin
          mem_ready = 1;
          if (mem_we) bmem[mem_addr[9:4]] = mem_wdata;
          else        mem_rdata = bmem[mem_addr[9:4]];
          resp_cycles += d + 1;
          active = 0;
        end else begin
          mem_ready = 0; cnt++;
        end
      end else begin
        active = 0;
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && mem_req) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual addr=%0h we=%0b required=no transaction", mem_addr, mem_we);
        end else begin
          chk("mem_we", 128'(mem_we), 128'(exp_mem[0].we));
          chk("mem_addr", 128'(mem_addr), 128'(exp_mem[0].addr));
          if (exp_mem[0].we) chk("mem_wdata", mem_wdata, exp_mem[0].data);
          if (mem_ready) void'(exp_mem.pop_front());
        end
      end
      if (!reset && dhit && cpu_rd && !cpu_wr) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata_unexpected actual=%0h required=no load", cpu_rdata);
        end else begin
          chk("cpu_rdata", 128'(cpu_rdata), 128'(exp_rd.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic run_directed(input int lat);
    lat_fixed = lat;
    do_reset();
    access(32'h100, 0, 1, 0, 0);             chk("cold_load", 128'(last_rd), 128'(1));
    access(32'h104, 1, 0, 0, 32'hDEADBEEF);  chk("store_hit_stall", 128'(last_stall), 128'(0));
    access(32'h104, 0, 1, 0, 0);             chk("load_after_store", 128'(last_rd), 128'(32'hDEADBEEF));
    access(32'h104, 1, 0, 0, 32'h11223344);
    access(32'h106, 1, 0, 1, 32'h000000AA);
    access(32'h104, 0, 1, 0, 0);             chk("byte_merge", 128'(last_rd), 128'(32'h11AA3344));
    access(32'h140, 0, 1, 0, 0);             chk("conflict_wb_stall", 128'(last_stall), 128'(2 * lat + 3));
    access(32'h104, 0, 1, 0, 0);             chk("reload_after_wb", 128'(last_rd), 128'(32'h11AA3344));
  endtask

  initial begin : main
    bit got, miss;
    logic [31:0] a, wd;
    int op;
    reset = 1; cpu_rd = 0; cpu_wr = 0; cpu_byte = 0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 64; i++) bmem[i] = {$urandom, $urandom, $urandom, $urandom};
    bmem[16] = {32'd4, 32'd3, 32'd2, 32'd1};
    #1;
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_mem_we", 128'(mem_we), 128'(0));
    chk("rst_dhit", 128'(dhit), 128'(1));

    run_directed(0);
    run_directed(5);

    // Reset while a fill is outstanding.
    lat_fixed = -1;
    do_reset();
    hold_ready = 1;
    model_access(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, miss);
    cpu_addr = 32'h100; cpu_rd = 1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = mem_req; end
    chk("fill_started", 128'(got), 128'(1));
    repeat (2) @(negedge clk);
    #1 reset = 1; cpu_rd = 0;
    #1;
    chk("abort_mem_req", 128'(mem_req), 128'(0));
    chk("abort_mem_we", 128'(mem_we), 128'(0));
    hold_ready = 0;
    do_reset();
    chk("abort_idle_dhit", 128'(dhit), 128'(1));
    access(32'h100, 0, 1, 0, 0);
    chk("reload_misses", 128'(last_stall != 0), 128'(1));

    // Request withdrawn mid-miss: write-back and fill complete, store is dropped.
    access(32'h230, 1, 0, 0, 32'hCAFEF00D);
    model_access(32'h270, 1'b1, 1'b0, 32'h55555555, 1'b0, miss);
    cpu_addr = 32'h270; cpu_wr = 1; cpu_wdata = 32'h55555555;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = mem_req; end
    chk("drop_miss_started", 128'(got), 128'(1));
    @(posedge clk); #1 cpu_wr = 0;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin @(negedge clk); got = !mem_req; end
    chk("drop_miss_finished", 128'(got), 128'(1));
    @(posedge clk); #1;
    chk("drop_idle_dhit", 128'(dhit), 128'(1));
    access(32'h270, 0, 1, 0, 0);
    access(32'h230, 0, 1, 0, 0);             chk("drop_wb_data", 128'(last_rd), 128'(32'hCAFEF00D));

    // Random traffic over 64 lines, four of which fit in the cache at a time.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a  = 32'($urandom_range(0, 1023));
      wd = $urandom;
      op = int'($urandom_range(0, 19));
      if (op < 9)       access(a, 0, 1, 0, 0);
      else if (op < 15) access(a, 1, 0, 0, wd);
      else if (op < 18) access(a, 1, 0, 1, wd);
      else              access(a, 1, 1, 0, wd);
      if ($urandom_range(0, 7) == 0) begin
        repeat (int'($urandom_range(1, 3))) @(posedge clk);
        #1;
      end
    end
    repeat (2) @(posedge clk);
    chk("mem_queue_drained", 128'(exp_mem.size()), 128'(0));
    chk("rd_queue_drained", 128'(exp_rd.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
